// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C init sequencer: state encoding, table word
// layout and the default HDMI transmitter register table.
package i2c_pkg;

   localparam int ENTRY_W = 16;
   localparam int REG_HI  = 15;
   localparam int REG_LO  = 8;
   localparam int DATA_HI = 7;
   localparam int DATA_LO = 0;

   localparam int HDMI_NUM_ENTRIES = 26;

   typedef enum logic [2:0] {
      ST_SETTLE = 3'd0,
      ST_ISSUE  = 3'd1,
      ST_ACCEPT = 3'd2,
      ST_BUSY   = 3'd3,
      ST_CHECK  = 3'd4,
      ST_DONE   = 3'd5,
      ST_FAIL   = 3'd6,
      ST_DRAIN  = 3'd7
   } seq_state_t;

   // Power-up, fixed registers, then video input/output format setup.
   function automatic logic [ENTRY_W-1:0] hdmi_init_entry(input logic [7:0] index);
      logic [ENTRY_W-1:0] word;
      case (index)
         8'd0:    word = 16'h4110;
         8'd1:    word = 16'h9803;
         8'd2:    word = 16'h9ae0;
         8'd3:    word = 16'h9c30;
         8'd4:    word = 16'h9d61;
         8'd5:    word = 16'ha2a4;
         8'd6:    word = 16'ha3a4;
         8'd7:    word = 16'he0d0;
         8'd8:    word = 16'hf900;
         8'd9:    word = 16'h1500;
         8'd10:   word = 16'h1630;
         8'd11:   word = 16'h1700;
         8'd12:   word = 16'h1846;
         8'd13:   word = 16'haf04;
         8'd14:   word = 16'h4080;
         8'd15:   word = 16'h4c04;
         8'd16:   word = 16'h4808;
         8'd17:   word = 16'h5510;
         8'd18:   word = 16'h5608;
         8'd19:   word = 16'h9620;
         8'd20:   word = 16'hd03c;
         8'd21:   word = 16'hde9c;
         8'd22:   word = 16'he460;
         8'd23:   word = 16'hfa7d;
         8'd24:   word = 16'hd6c0;
         8'd25:   word = 16'hba60;
         default: word = '0;
      endcase
      return word;
   endfunction

endpackage

// File: rtl/i2c_init_table.sv
// Combinational ROM holding the default HDMI init table; indices past
// NUM_ENTRIES read as zero.
module i2c_init_table
   import i2c_pkg::*;
#(
   parameter int NUM_ENTRIES = HDMI_NUM_ENTRIES,
   parameter int IDX_W       = 8
) (
   input  logic [IDX_W-1:0]   tbl_index,
   output logic [ENTRY_W-1:0] tbl_data
);

   logic [ENTRY_W-1:0] rom [2**IDX_W];

   for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_rom
      if (gi < NUM_ENTRIES) begin : g_used
         assign rom[gi] = hdmi_init_entry(8'(gi));
      end else begin : g_unused
         assign rom[gi] = '0;
      end
   end

   assign tbl_data = rom[tbl_index];

endmodule

// File: rtl/i2c_init_sequencer.sv
// Walks a register table issuing one I2C write per entry, with NACK retries,
// accept timeout, and rerun on restart or a falling device interrupt.
module i2c_init_sequencer
   import i2c_pkg::*;
#(
   parameter int         NUM_ENTRIES    = 26,
   parameter int         ENTRY_W        = i2c_pkg::ENTRY_W,
   parameter logic [7:0] DEV_ADDR       = 8'h72,
   parameter int         MAX_RETRIES    = 3,
   parameter int         SETTLE_CYCLES  = 4,
   parameter int         ACCEPT_TIMEOUT = 64,
   parameter int         IDX_W          = 8
) (
   input  logic               clk_in,
   input  logic               reset,
   input  logic               restart,
   input  logic               hdmi_tx_int,
   output logic [IDX_W-1:0]   tbl_index,
   input  logic [ENTRY_W-1:0] tbl_data,
   output logic               start,
   output logic [7:0]         dev_addr,
   output logic [ENTRY_W-1:0] reg_data,
   input  logic               ready,
   input  logic               ack,
   output logic               init_done,
   output logic               init_error,
   output logic [IDX_W-1:0]   entry_count,
   output logic [3:0]         retry_count,
   output logic [2:0]         state_out
);

   localparam int               TO_W        = $clog2(ACCEPT_TIMEOUT + 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_ENTRIES - 1);
   localparam logic [IDX_W-1:0] ENTRY_MAX   = IDX_W'(NUM_ENTRIES);
   localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRIES);
   localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(ACCEPT_TIMEOUT - 1);

   seq_state_t         state_reg, state_next;
   logic [7:0]         settle_cnt_reg, settle_cnt_next;
   logic [TO_W-1:0]    timeout_cnt_reg, timeout_cnt_next;
   logic [IDX_W-1:0]   tbl_index_reg, tbl_index_next;
   logic [IDX_W-1:0]   entry_count_reg, entry_count_next;
   logic [3:0]         retry_count_reg, retry_count_next;
   logic               start_reg, start_next;
   logic [ENTRY_W-1:0] reg_data_reg, reg_data_next;
   logic               init_done_reg, init_done_next;
   logic               init_error_reg, init_error_next;

   // Interrupt synchroniser plus one history flop for edge detection.
   logic int_meta_reg, int_sync_reg, int_prev_reg;
   logic fall_event, rerun_req;
   logic attempt_ok, attempt_bad, apply_rerun;

   assign fall_event = int_prev_reg & ~int_sync_reg;
   assign rerun_req  = restart | fall_event;

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         int_meta_reg    <= 1'b1;
         int_sync_reg    <= 1'b1;
         int_prev_reg    <= 1'b1;
         state_reg       <= ST_SETTLE;
         settle_cnt_reg  <= '0;
         timeout_cnt_reg <= '0;
         tbl_index_reg   <= '0;
         entry_count_reg <= '0;
         retry_count_reg <= '0;
         start_reg       <= 1'b0;
         reg_data_reg    <= '0;
         init_done_reg   <= 1'b0;
         init_error_reg  <= 1'b0;
      end else begin
         int_meta_reg    <= hdmi_tx_int;
         int_sync_reg    <= int_meta_reg;
         int_prev_reg    <= int_sync_reg;
         state_reg       <= state_next;
         settle_cnt_reg  <= settle_cnt_next;
         timeout_cnt_reg <= timeout_cnt_next;
         tbl_index_reg   <= tbl_index_next;
         entry_count_reg <= entry_count_next;
         retry_count_reg <= retry_count_next;
         start_reg       <= start_next;
         reg_data_reg    <= reg_data_next;
         init_done_reg   <= init_done_next;
         init_error_reg  <= init_error_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      settle_cnt_next  = settle_cnt_reg;
      timeout_cnt_next = timeout_cnt_reg;
      tbl_index_next   = tbl_index_reg;
      entry_count_next = entry_count_reg;
      retry_count_next = retry_count_reg;
      start_next       = start_reg;
      reg_data_next    = reg_data_reg;
      init_done_next   = init_done_reg;
      init_error_next  = init_error_reg;
      attempt_ok       = 1'b0;
      attempt_bad      = 1'b0;
      apply_rerun      = 1'b0;

      case (state_reg)
         ST_SETTLE: begin
            if (settle_cnt_reg < SETTLE_LAST) begin
               settle_cnt_next = settle_cnt_reg + 8'd1;
            end else if (ready) begin
               settle_cnt_next = '0;
               state_next      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            reg_data_next    = tbl_data;
            start_next       = 1'b1;
            timeout_cnt_next = '0;
            state_next       = ST_ACCEPT;
         end
         ST_ACCEPT: begin
            if (!ready) begin
               start_next = 1'b0;
               state_next = ST_BUSY;
            end else if (timeout_cnt_reg == TO_LAST) begin
               // Controller never took the request: treat like a NACK.
               start_next  = 1'b0;
               attempt_bad = 1'b1;
            end else begin
               timeout_cnt_next = timeout_cnt_reg + 1'b1;
            end
         end
         ST_BUSY:  if (ready) state_next = ST_CHECK;
         ST_CHECK: begin
            if (ack) attempt_ok  = 1'b1;
            else     attempt_bad = 1'b1;
         end
         ST_DONE:  init_done_next  = 1'b1;
         ST_FAIL:  init_error_next = 1'b1;
         ST_DRAIN: if (ready) apply_rerun = 1'b1;
         default:  state_next = ST_SETTLE;
      endcase

      if (attempt_ok) begin
         retry_count_next = '0;
         if (entry_count_reg < ENTRY_MAX) entry_count_next = entry_count_reg + 1'b1;
         if (tbl_index_reg == LAST_IDX) begin
            init_done_next = 1'b1;
            state_next     = ST_DONE;
         end else begin
            tbl_index_next  = tbl_index_reg + 1'b1;
            settle_cnt_next = '0;
            state_next      = ST_SETTLE;
         end
      end

      if (attempt_bad) begin
         if (retry_count_reg < RETRY_MAX) begin
            retry_count_next = retry_count_reg + 4'd1;
            settle_cnt_next  = '0;
            state_next       = ST_SETTLE;
         end else begin
            init_error_next = 1'b1;
            state_next      = ST_FAIL;
         end
      end

      // A rerun while the controller owns the bus waits in DRAIN; further
      // rerun requests there are absorbed.
      if (rerun_req && state_reg != ST_DRAIN) begin
         if (state_reg == ST_ACCEPT || state_reg == ST_BUSY) begin
            start_next = 1'b0;
            state_next = ST_DRAIN;
         end else begin
            apply_rerun = 1'b1;
         end
      end

      if (apply_rerun) begin
         tbl_index_next   = '0;
         entry_count_next = '0;
         retry_count_next = '0;
         init_done_next   = 1'b0;
         init_error_next  = 1'b0;
         start_next       = 1'b0;
         settle_cnt_next  = '0;
         state_next       = ST_SETTLE;
      end
   end

   assign tbl_index   = tbl_index_reg;
   assign start       = start_reg;
   assign dev_addr    = DEV_ADDR;
   assign reg_data    = reg_data_reg;
   assign init_done   = init_done_reg;
   assign init_error  = init_error_reg;
   assign entry_count = entry_count_reg;
   assign retry_count = retry_count_reg;
   assign state_out   = state_reg;

endmodule

// File: doc/i2c_init_sequencer.md
Name: i2c_init_sequencer

Overview:
- Parametrised successor to the single-purpose HDMI transmitter init loop.
- Walks a table of NUM_ENTRIES 16-bit {reg, data} words and issues one i2c_controller transaction per entry to device DEV_ADDR.
- Retries on NACK and aborts with an error after MAX_RETRIES.
- Re-runs the whole sequence on a restart pulse or a falling edge of the device interrupt line. Sits between the I2C bit-level controller and the display pipeline's "ready" logic.

Parameters:
- NUM_ENTRIES, 26: number of table entries written (1..255).
- ENTRY_W, 16: table word width; upper 8 bits are the register, lower 8 bits are the data.
- DEV_ADDR, 8'h72: 8-bit I2C write address presented on dev_addr.
- MAX_RETRIES, 3: extra attempts per entry after a NACK (0..15).
- SETTLE_CYCLES, 4: idle cycles between transactions (1..255).
- ACCEPT_TIMEOUT, 64: cycles to wait for ready to fall after start before the attempt is counted as a failure.
- IDX_W, 8: width of tbl_index and entry_count.

Ports:
- clk_in  in  1  transaction-rate clock (same clock as i2c_controller).
- reset  in  1  asynchronous, active-high reset.
- restart  in  1  one-cycle pulse; rerun the sequence from entry 0.
- hdmi_tx_int  in  1  active-low device interrupt, synchronised here; its falling edge triggers a rerun.
- tbl_index  out  IDX_W  entry currently addressed in the external table.
- tbl_data  in  ENTRY_W  table word for tbl_index; combinational, valid in the same cycle.
- start  out  1  transaction request to i2c_controller.
- dev_addr  out  8  constant DEV_ADDR.
- reg_data  out  ENTRY_W  registered copy of tbl_data for the active transaction.
- ready  in  1  controller idle (1) or busy (0).
- ack  in  1  1 = slave acknowledged the last transaction; valid when ready returns to 1.
- init_done  out  1  all entries written successfully.
- init_error  out  1  an entry exhausted its retries, or an accept timeout occurred on the final attempt.
- entry_count  out  IDX_W  number of entries completed successfully.
- retry_count  out  4  retries used on the current entry.
- state_out  out  3  encoded state, for debug.

Behaviour:
- Reset values: start=0, tbl_index=0, reg_data=0, init_done=0, init_error=0, entry_count=0, retry_count=0, state=SETTLE, settle counter=0. dev_addr equals DEV_ADDR at all times.
- hdmi_tx_int passes through a 2-flop synchroniser; a fall event is synchronised 1→0.
- SETTLE: count SETTLE_CYCLES cycles. Then go to ISSUE if ready=1; otherwise stay in SETTLE.
- ISSUE: latch reg_data<=tbl_data, set start<=1, clear the timeout counter, go to ACCEPT.
- ACCEPT: hold start=1 until ready=0, then start<=0 and go to BUSY. If the timeout counter reaches ACCEPT_TIMEOUT first: start<=0 and handle as a NACK.
- BUSY: wait for ready=1, then go to CHECK. Duration is unbounded; the controller owns timing.
- CHECK on ack=1: entry_count+1, retry_count<=0.
  - If tbl_index==NUM_ENTRIES-1, go to DONE.
  - Otherwise tbl_index+1 and go to SETTLE.
- CHECK on ack=0:
  - If retry_count<MAX_RETRIES: retry_count+1, go to SETTLE with the same index.
  - Otherwise set init_error=1 and go to FAIL.
- DONE: init_done=1 and hold.
- FAIL: init_error=1 and hold. No further transactions in either state.
- Rerun (restart pulse or fall event) in any state:
  - Next cycle: tbl_index=0, entry_count=0, retry_count=0, init_done=0, init_error=0, start=0, state=SETTLE.
  - If a transaction is in flight (ACCEPT or BUSY), first go to DRAIN, wait for ready=1, then apply the rerun. A controller transfer is never cut off mid-byte.
- Simultaneous restart and fall event: one rerun only.
- Rerun arriving while already in DRAIN: absorbed; still one rerun.
- Reset mid-transaction: outputs return to their reset values immediately. The controller shares the reset.
- Latency: ISSUE to start=1 is 1 cycle. Minimum gap between the CHECK of one entry and the ISSUE of the next is SETTLE_CYCLES+1.
- Arithmetic: no counter may wrap. entry_count saturates at NUM_ENTRIES; retry_count saturates at MAX_RETRIES.

Decomposition:
- Shared package (i2c_pkg):
  - state encoding SETTLE, ISSUE, ACCEPT, BUSY, CHECK, DONE, FAIL, DRAIN, encoded in 3 bits;
  - ENTRY_W;
  - REG/DATA field slice constants;
  - the default HDMI transmitter table as a function hdmi_init_entry(index).
- One natural sub-module: i2c_init_table. It is a combinational ROM wrapper driving tbl_data from tbl_index, and is instantiated alongside the sequencer, not inside it.

Test Plan:
- NUM_ENTRIES=3, table {0x4110, 0x9803, 0xfa7d}, model always acks → exactly 3 start pulses with reg_data in that order. Then init_done=1, entry_count=3, init_error=0, and no 4th start.
- Model NACKs entry 1 twice and then acks (MAX_RETRIES=3) → entry 1 is issued 3 times with reg_data=0x9803 each time. retry_count reads 1, then 2, then back to 0; init_done=1.
- Model always NACKs entry 2, MAX_RETRIES=3 → 4 attempts on 0xfa7d, then init_error=1, init_done=0, entry_count=2, and no further start.
- Model holds ready=1 after start, ACCEPT_TIMEOUT=64 → start drops after 64 cycles, each timeout counts as a retry, and init_error=1 after 4 timeouts.
- hdmi_tx_int is pulled low for 5 cycles while in DONE → after the 2-cycle synchroniser, init_done=0. The sequence reruns from 0x4110 and completes again.
- Restart pulse during BUSY on entry 1 → the controller finishes its transfer (ready=1), and then the next start carries entry 0's data. No start occurs while ready=0.
